muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: ITER, default 32, meaning the number of iteration cycles per multiply or divide.
REQ-002 Port: clk, input, 1, clock; all state updates on the rising edge.
REQ-003 Port: rst, input, 1, reset, synchronous, active-high.
REQ-004 Port: start, input, 1, launches an operation from the EX stage.
REQ-005 Port: op, input, 2, operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Port: rs_data, input, 32, multiplicand or dividend.
REQ-007 Port: rt_data, input, 32, multiplier or divisor.
REQ-008 Port: mthi, input, 1, writes rs_data to HI.
REQ-009 Port: mtlo, input, 1, writes rs_data to LO.
REQ-010 Port: hilo_read, input, 1, an MFHI/MFLO is in EX.
REQ-011 Port: hi, output, 32, HI register.
REQ-012 Port: lo, output, 32, LO register.
REQ-013 Port: busy, output, 1, an operation is in progress.
REQ-014 Port: done, output, 1, one-cycle completion pulse.
REQ-015 Port: div_zero, output, 1, the last divide had divisor 0; held until the next start.
REQ-016 Port: stall, output, 1, hazard request to the pipeline control.

Function
REQ-017 The FSM SHALL have states IDLE, MUL, DIV and FIN.
- IDLE: start with op[1]=0 goes to MUL; start with op[1]=1 goes to DIV.
- MUL and DIV: stay for exactly ITER cycles, counted by a 6-bit counter, then go to FIN.
- FIN: returns to IDLE.
REQ-018 start SHALL be sampled only in IDLE; start while busy SHALL be ignored, and operands are latched on the accepting edge.
REQ-019 busy SHALL be 1 in MUL, DIV and FIN, and 0 in IDLE.
REQ-020 The FIN edge SHALL update hi and lo and assert done for one cycle; results are visible ITER+1 cycles after the start edge.
REQ-021 Multiply SHALL use shift-add, one multiplier bit per cycle, with a 64-bit product giving {hi, lo}.
REQ-022 Divide SHALL use restoring division, one quotient bit per cycle; lo is the quotient and hi is the remainder.
REQ-023 Signed operations SHALL work on operand magnitudes and then correct signs:
- product is negated if the operand signs differ;
- quotient is negated if the signs differ;
- remainder takes the sign of the dividend.
REQ-024 Divisor 0 SHALL give lo=32'hFFFFFFFF, hi=rs_data and div_zero=1, with the full ITER latency.
REQ-025 For DIV of 32'h80000000 by 32'hFFFFFFFF, the result SHALL be lo=32'h80000000, hi=0.
REQ-026 mthi/mtlo SHALL write on the edge when not busy; while busy they SHALL be ignored.
REQ-027 stall SHALL equal busy & (hilo_read | start | mthi | mtlo), so the pipeline control holds EX until IDLE.
REQ-028 On a same-edge start and mthi/mtlo in IDLE, both SHALL take effect, and the operation result overwrites later.

Reset
REQ-029 On rst: hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, state=IDLE.
REQ-030 rst during MUL/DIV SHALL abort the operation with no hi/lo update and no done pulse.

Configuration
REQ-031 Macro MULDIV_SIGNED_EN controls signed operations.
- Defined: MULT and DIV are signed per REQ-023 and REQ-025.
- Undefined: op[0] is ignored, all operations are unsigned, and no sign-correction logic is built.

Structure
REQ-032 Package muldiv_pkg SHALL hold:
- the op encodings;
- the FSM state type;
- the ITER default;
- the 32'hFFFFFFFF div-zero quotient constant.
REQ-033 One combinational sub-module, muldiv_sign_fix, SHALL perform operand magnitude and result negation; all other logic is in muldiv_unit.

Verification
REQ-034 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> after 33 cycles, hi=32'hFFFFFFFE, lo=32'h00000001, done pulses once.
REQ-035 MULT -3 x 7 (with MULDIV_SIGNED_EN) -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; without the macro -> hi=32'h00000006, lo=32'hFFFFFFEB.
REQ-036 DIV -7 / 2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; DIVU 100 / 7 -> lo=14, hi=2.
REQ-037 DIVU 100 / 0 -> lo=32'hFFFFFFFF, hi=32'h00000064, div_zero=1 until the next start.
REQ-038 Second start and mthi at cycle 5 of a MULTU -> both ignored, stall=1 in that cycle, and the first result is unchanged.
REQ-039 rst asserted at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, no done pulse, and a new start is accepted immediately.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Signed operation support is selected with the MULDIV_SIGNED_EN macro.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    FIN  = 2'b11
  } state_e;

  localparam int          ITER_DEFAULT  = 32;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and result sign correction for muldiv_unit.
// With MULDIV_SIGNED_EN undefined this is a pure pass-through (no negators built).
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic        op_signed,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        neg_res,
  input  logic        neg_rem,
  input  logic [63:0] prod_raw,
  input  logic [31:0] quot_raw,
  input  logic [31:0] rem_raw,
  output logic [31:0] rs_mag,
  output logic [31:0] rt_mag,
  output logic        neg_res_next,
  output logic        neg_rem_next,
  output logic [63:0] prod_fix,
  output logic [31:0] quot_fix,
  output logic [31:0] rem_fix
);

`ifdef MULDIV_SIGNED_EN
  logic rs_neg_s;
  logic rt_neg_s;

  // Magnitudes on the way in, two's-complement correction on the way out
  always_comb begin
    rs_neg_s     = op_signed & rs_data[31];
    rt_neg_s     = op_signed & rt_data[31];
    rs_mag       = rs_neg_s ? (32'd0 - rs_data) : rs_data;
    rt_mag       = rt_neg_s ? (32'd0 - rt_data) : rt_data;
    neg_res_next = rs_neg_s ^ rt_neg_s;
    neg_rem_next = rs_neg_s;
    prod_fix     = neg_res ? (64'd0 - prod_raw) : prod_raw;
    quot_fix     = neg_res ? (32'd0 - quot_raw) : quot_raw;
    rem_fix      = neg_rem ? (32'd0 - rem_raw) : rem_raw;
  end
`else
  logic unused_s;

  assign rs_mag       = rs_data;
  assign rt_mag       = rt_data;
  assign neg_res_next = 1'b0;
  assign neg_rem_next = 1'b0;
  assign prod_fix     = prod_raw;
  assign quot_fix     = quot_raw;
  assign rem_fix      = rem_raw;
  assign unused_s     = ^{op_signed, neg_res, neg_rem};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle. MULDIV_SIGNED_EN enables signed MULT/DIV.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        hilo_read,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        stall
);

  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  state_e      state_r;
  logic [5:0]  cnt_r;
  logic [63:0] work_r;
  logic [31:0] opb_r;
  logic [31:0] rs_hold_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;
  logic        is_div_r;
  logic        neg_res_r;
  logic        neg_rem_r;
  logic        busy_r;
  logic        done_r;
  logic        div_zero_r;

  logic        op_div_s;
  logic        op_signed_s;
  logic [31:0] rs_mag_s;
  logic [31:0] rt_mag_s;
  logic        neg_res_s;
  logic        neg_rem_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_shift_s;
  logic [31:0] div_diff_s;
  logic [63:0] div_next_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quot_fix_s;
  logic [31:0] rem_fix_s;

  assign op_div_s    = (op == OP_DIVU) || (op == OP_DIV);
  assign op_signed_s = (op == OP_MULT) || (op == OP_DIV);

  muldiv_sign_fix u_sign_fix (
    .op_signed    (op_signed_s),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .neg_res      (neg_res_r),
    .neg_rem      (neg_rem_r),
    .prod_raw     (work_r),
    .quot_raw     (work_r[31:0]),
    .rem_raw      (work_r[63:32]),
    .rs_mag       (rs_mag_s),
    .rt_mag       (rt_mag_s),
    .neg_res_next (neg_res_s),
    .neg_rem_next (neg_rem_s),
    .prod_fix     (prod_fix_s),
    .quot_fix     (quot_fix_s),
    .rem_fix      (rem_fix_s)
  );

  // One iteration step; work_r is {acc, multiplier} for MUL and {rem, quot} for DIV
  always_comb begin
    mul_sum_s   = {1'b0, work_r[63:32]} + (work_r[0] ? {1'b0, opb_r} : 33'd0);
    mul_next_s  = {mul_sum_s, work_r[31:1]};
    div_shift_s = work_r[63:31];
    div_diff_s  = 32'(div_shift_s - {1'b0, opb_r});
    if (div_shift_s >= {1'b0, opb_r}) begin
      div_next_s = {div_diff_s, work_r[30:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[31:0], work_r[30:0], 1'b0};
    end
  end

  // Control FSM, iteration datapath and architectural HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 6'd0;
      work_r     <= 64'd0;
      opb_r      <= 32'd0;
      rs_hold_r  <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      is_div_r   <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mthi) hi_r <= rs_data;
          if (mtlo) lo_r <= rs_data;
          if (start) begin
            cnt_r      <= 6'd0;
            opb_r      <= op_div_s ? rt_mag_s : rs_mag_s;
            work_r     <= {32'd0, (op_div_s ? rs_mag_s : rt_mag_s)};
            rs_hold_r  <= rs_data;
            is_div_r   <= op_div_s;
            neg_res_r  <= neg_res_s;
            neg_rem_r  <= neg_rem_s;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= op_div_s ? DIV : MUL;
          end
        end
        MUL, DIV: begin
          work_r <= (state_r == DIV) ? div_next_s : mul_next_s;
          cnt_r  <= cnt_r + 6'd1;
          if (cnt_r == LAST_CNT) state_r <= FIN;
        end
        FIN: begin
          // Divide-by-zero bypasses sign correction: quotient all ones, HI keeps the raw dividend
          if (is_div_r) begin
            if (opb_r == 32'd0) begin
              hi_r       <= rs_hold_r;
              lo_r       <= DIV_ZERO_QUOT;
              div_zero_r <= 1'b1;
            end else begin
              hi_r       <= rem_fix_s;
              lo_r       <= quot_fix_s;
              div_zero_r <= 1'b0;
            end
          end else begin
            {hi_r, lo_r} <= prod_fix_s;
          end
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign hi       = hi_r;
  assign lo       = lo_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign stall    = busy_r & (hilo_read | start | mthi | mtlo);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations against an arithmetic reference model (honours MULDIV_SIGNED_EN).
module tb_muldiv_unit;

  localparam int ITER = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        hilo_read = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero, stall;

  int checks_total = 0;
  int checks_passed = 0;

  muldiv_unit #(.ITER(ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .mthi(mthi), .mtlo(mtlo), .hilo_read(hilo_read), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div_zero(div_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Expected {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic   sgn;
    longint sa, sb;
    logic [63:0] res;
`ifdef MULDIV_SIGNED_EN
    sgn = o[0];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (!o[1]) res = 64'(sa * sb);
    else if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
    else res = {32'(sa % sb), 32'(sa / sb)};
    return res;
  endfunction

  // Launch one op from IDLE and watch it for a bounded number of cycles
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int npulse, output int nbusy);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; npulse = 0; nbusy = 0;
    for (int i = 1; i <= ITER + 4; i++) begin
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (lat == 0) lat = i;
      end
      if (busy) nbusy++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hilo_read = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks_total++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); else checks_passed++;
    checks_total++; if ({busy, done, div_zero} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero}); else checks_passed++;
    checks_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else checks_passed++;
    rst = 1'b0; hilo_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int lat, np, nb;
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, np, nb);
    checks_total++; if (lat !== ITER + 1) $display("FAIL multu_latency: got %0d expected %0d", lat, ITER + 1); else checks_passed++;
    checks_total++; if (np !== 1) $display("FAIL multu_done_pulses: got %0d expected 1", np); else checks_passed++;
    checks_total++; if (nb !== ITER) $display("FAIL multu_busy_cycles: got %0d expected %0d", nb, ITER); else checks_passed++;
    checks_total++; if (hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi: got %h expected fffffffe", hi); else checks_passed++;
    checks_total++; if (lo !== 32'h0000_0001) $display("FAIL multu_lo: got %h expected 00000001", lo); else checks_passed++;
  endtask

  task automatic test_mult();
    int lat, np, nb;
    logic [63:0] exp;
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, lat, np, nb);
`ifdef MULDIV_SIGNED_EN
    exp = {32'hFFFF_FFFF, 32'hFFFF_FFEB};
`else
    exp = {32'h0000_0006, 32'hFFFF_FFEB};
`endif
    checks_total++; if ({hi, lo} !== exp) $display("FAIL mult_neg3x7: got %h expected %h", {hi, lo}, exp); else checks_passed++;
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, lat, np, nb);
    exp = ref_model(2'b01, 32'h8000_0000, 32'h8000_0000);
    checks_total++; if ({hi, lo} !== exp) $display("FAIL mult_min_sq: got %h expected %h", {hi, lo}, exp); else checks_passed++;
  endtask

  task automatic test_div();
    int lat, np, nb;
    logic [63:0] exp;
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat, np, nb);
`ifdef MULDIV_SIGNED_EN
    exp = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
`else
    exp = ref_model(2'b11, 32'hFFFF_FFF9, 32'd2);
`endif
    checks_total++; if ({hi, lo} !== exp) $display("FAIL div_neg7by2: got %h expected %h", {hi, lo}, exp); else checks_passed++;
    do_op(2'b10, 32'd100, 32'd7, lat, np, nb);
    checks_total++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL divu_100by7: got %h expected %h", {hi, lo}, {32'd2, 32'd14}); else checks_passed++;
    checks_total++; if (lat !== ITER + 1) $display("FAIL divu_latency: got %0d expected %0d", lat, ITER + 1); else checks_passed++;
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat, np, nb);
    exp = ref_model(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    checks_total++; if ({hi, lo} !== exp) $display("FAIL div_overflow: got %h expected %h", {hi, lo}, exp); else checks_passed++;
  endtask

  task automatic test_div_zero();
    int lat, np, nb;
    do_op(2'b10, 32'd100, 32'd0, lat, np, nb);
    checks_total++; if ({hi, lo} !== {32'h0000_0064, 32'hFFFF_FFFF}) $display("FAIL divu_zero_result: got %h expected 00000064ffffffff", {hi, lo}); else checks_passed++;
    checks_total++; if (lat !== ITER + 1) $display("FAIL divu_zero_latency: got %0d expected %0d", lat, ITER + 1); else checks_passed++;
    checks_total++; if (div_zero !== 1'b1) $display("FAIL div_zero_set: got %b expected 1", div_zero); else checks_passed++;
    repeat (3) @(posedge clk);
    #1;
    checks_total++; if (div_zero !== 1'b1) $display("FAIL div_zero_held: got %b expected 1", div_zero); else checks_passed++;
    do_op(2'b11, 32'hFFFF_FF00, 32'd0, lat, np, nb);
    checks_total++; if ({hi, lo} !== {32'hFFFF_FF00, 32'hFFFF_FFFF}) $display("FAIL div_zero_signed: got %h expected ffffff00ffffffff", {hi, lo}); else checks_passed++;
    start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    checks_total++; if (div_zero !== 1'b0) $display("FAIL div_zero_clear_on_start: got %b expected 0", div_zero); else checks_passed++;
    for (int i = 0; i < ITER + 3 && busy; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_ignore();
    int lat, np;
    logic [31:0] hi_before, lo_before;
    logic [63:0] exp;
    exp = ref_model(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    hi_before = hi; lo_before = lo;
    start = 1'b1; op = 2'b00; rs_data = 32'h1234_5678; rt_data = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; np = 0;
    for (int i = 1; i <= ITER + 4; i++) begin
      if (i == 5) begin
        start = 1'b1; op = 2'b10; rs_data = 32'hDEAD_BEEF; rt_data = 32'd1; mthi = 1'b1; mtlo = 1'b1;
        #1;
        checks_total++; if (stall !== 1'b1) $display("FAIL busy_stall_start: got %b expected 1", stall); else checks_passed++;
      end
      if (i == 7) begin
        hilo_read = 1'b1;
        #1;
        checks_total++; if (stall !== 1'b1) $display("FAIL busy_stall_read: got %b expected 1", stall); else checks_passed++;
      end
      if (i == 8) begin
        hilo_read = 1'b0;
        #1;
        checks_total++; if (stall !== 1'b0) $display("FAIL busy_no_request: got %b expected 0", stall); else checks_passed++;
      end
      @(posedge clk); #1;
      if (i == 5) begin
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checks_total++; if ({hi, lo} !== {hi_before, lo_before}) $display("FAIL busy_mthi_ignored: got %h expected %h", {hi, lo}, {hi_before, lo_before}); else checks_passed++;
      end
      if (done) begin
        np++;
        if (lat == 0) lat = i;
      end
    end
    checks_total++; if (lat !== ITER + 1) $display("FAIL busy_latency: got %0d expected %0d", lat, ITER + 1); else checks_passed++;
    checks_total++; if (np !== 1) $display("FAIL busy_done_pulses: got %0d expected 1", np); else checks_passed++;
    checks_total++; if ({hi, lo} !== exp) $display("FAIL busy_result: got %h expected %h", {hi, lo}, exp); else checks_passed++;
  endtask

  task automatic test_same_edge();
    int lat, np, nb;
    hilo_read = 1'b1; mtlo = 1'b1; rs_data = 32'hA5A5_0001;
    #1;
    checks_total++; if (stall !== 1'b0) $display("FAIL idle_no_stall: got %b expected 0", stall); else checks_passed++;
    @(posedge clk); #1;
    hilo_read = 1'b0; mtlo = 1'b0;
    checks_total++; if (lo !== 32'hA5A5_0001) $display("FAIL mtlo_idle: got %h expected a5a50001", lo); else checks_passed++;
    start = 1'b1; mthi = 1'b1; op = 2'b00; rs_data = 32'hF000_0001; rt_data = 32'h0000_0010;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    checks_total++; if (hi !== 32'hF000_0001) $display("FAIL same_edge_mthi: got %h expected f0000001", hi); else checks_passed++;
    lat = 0;
    for (int i = 1; i <= ITER + 4; i++) begin
      @(posedge clk); #1;
      if (done && lat == 0) lat = i;
    end
    checks_total++; if ({hi, lo} !== 64'h0000_000F_0000_0010) $display("FAIL same_edge_result: got %h expected 0000000f00000010", {hi, lo}); else checks_passed++;
    np = 0; nb = 0;
  endtask

  task automatic test_rst_abort();
    int lat, np, nb, early;
    start = 1'b1; op = 2'b11; rs_data = 32'hFFFF_FF9C; rt_data = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    early = 0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) early++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks_total++; if ({busy, done} !== 2'b00) $display("FAIL abort_flags: got %b expected 00", {busy, done}); else checks_passed++;
    checks_total++; if ({hi, lo} !== 64'd0) $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); else checks_passed++;
    checks_total++; if (early !== 0) $display("FAIL abort_early_done: got %0d expected 0", early); else checks_passed++;
    do_op(2'b10, 32'd1000, 32'd33, lat, np, nb);
    checks_total++; if (lat !== ITER + 1) $display("FAIL abort_restart_latency: got %0d expected %0d", lat, ITER + 1); else checks_passed++;
    checks_total++; if ({hi, lo} !== {32'd10, 32'd30}) $display("FAIL abort_restart_result: got %h expected %h", {hi, lo}, {32'd10, 32'd30}); else checks_passed++;
  endtask

  task automatic test_random();
    int lat, np, nb;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int n = 0; n < 24; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      exp = ref_model(o, a, b);
      do_op(o, a, b, lat, np, nb);
      checks_total++; if ({hi, lo} !== exp) $display("FAIL rand_result op=%0d a=%h b=%h: got %h expected %h", o, a, b, {hi, lo}, exp); else checks_passed++;
      checks_total++; if (div_zero !== (o[1] && b == 32'd0)) $display("FAIL rand_div_zero op=%0d b=%h: got %b expected %b", o, b, div_zero, (o[1] && b == 32'd0)); else checks_passed++;
      checks_total++; if (lat !== ITER + 1 || np !== 1) $display("FAIL rand_timing: got lat %0d pulses %0d expected %0d and 1", lat, np, ITER + 1); else checks_passed++;
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_same_edge();
    test_rst_abort();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
